// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
// Shared definitions for the two-master Wishbone B3 arbiter: the arbiter
// state encoding plus the Wishbone cycle-type (CTI) and burst-type (BTE)
// codes used by masters, slaves and the arbiter's testbench.
// No ports; imported by the arbiter, its watchdog and the testbench.

package wb_arb_pkg;

  // Arbiter states: bus free, or granted to master 0 / master 1
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  // Wishbone B3 cycle type identifiers
  localparam logic [2:0] CLASSIC = 3'b000;
  localparam logic [2:0] CONST   = 3'b001;
  localparam logic [2:0] INCR    = 3'b010;
  localparam logic [2:0] EOB     = 3'b111;

  // Wishbone B3 burst type extensions
  localparam logic [1:0] LINEAR = 2'b00;
  localparam logic [1:0] WRAP4  = 2'b01;
  localparam logic [1:0] WRAP8  = 2'b10;
  localparam logic [1:0] WRAP16 = 2'b11;

endpackage

// File: rtl/wb_watchdog.sv
// wb_watchdog
// Counts consecutive strobe cycles that the slave leaves unanswered and
// raises a one-cycle fire pulse when the count reaches timeout_cycles.
// A timeout_cycles of 0 disables the pulse entirely.
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset
//   clear     - bus is not granted; hold the counter at zero
//   busy      - granted master is strobing the slave this cycle
//   responded - slave answered with ack, err or rty this cycle
//   fire      - combinational timeout pulse for the current cycle

module wb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int timeout_cycles = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic busy,
  input  logic responded,
  output logic fire
);

  localparam logic [7:0] LIMIT   = 8'(timeout_cycles - 1);
  localparam bit         ENABLED = (timeout_cycles != 0);

  logic [7:0] wd_cnt_q;
  logic [7:0] wd_cnt_d;
  logic       count_en;

  // The pulse fires in the cycle that would have been the timeout_cycles-th
  // unanswered strobe, so the counter compares against timeout_cycles-1.
  always_comb begin
    count_en = busy && !responded && !clear;
    fire     = ENABLED && count_en && (wd_cnt_q == LIMIT);
    wd_cnt_d = '0;
    if (count_en && !fire) begin
      wd_cnt_d = wd_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule

// File: rtl/wb_arb2_b3.sv
// wb_arb2_b3
// Round-robin arbiter letting two Wishbone B3 masters share one slave.
// A grant is held for the whole cyc assertion so bursts pass untouched,
// and a watchdog ends any access the slave never answers.
// Ports:
//   wb_clk_i, wb_rst_i        - clock, synchronous active-high reset
//   m0_* / m1_*               - master-side request inputs and response outputs
//   s_*_o                     - slave-side request outputs (mux of granted master)
//   s_dat_i/ack/err/rty       - slave responses, routed to the granted master

module wb_arb2_b3
  import wb_arb_pkg::*;
#(
  parameter int dw             = 32,
  parameter int aw             = 32,
  parameter int timeout_cycles = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,

  input  logic [aw-1:0] m0_adr_i,
  input  logic [dw-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_we_i,
  input  logic [1:0]    m0_bte_i,
  input  logic [2:0]    m0_cti_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  output logic [dw-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,

  input  logic [aw-1:0] m1_adr_i,
  input  logic [dw-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  input  logic [1:0]    m1_bte_i,
  input  logic [2:0]    m1_cti_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  output logic [dw-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,

  output logic [aw-1:0] s_adr_o,
  output logic [dw-1:0] s_dat_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  output logic [1:0]    s_bte_o,
  output logic [2:0]    s_cti_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic [dw-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       wd_fire;
  logic       wd_busy;

  // Watchdog sees the master's own strobe, before the fire pulse masks it,
  // so the pulse cannot feed back into its own trigger condition.
  assign wd_busy = ((state_q == GNT0) && m0_stb_i) ||
                   ((state_q == GNT1) && m1_stb_i);

  wb_watchdog #(
    .timeout_cycles(timeout_cycles)
  ) u_watchdog (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .clear    (state_q == IDLE),
    .busy     (wd_busy),
    .responded(s_ack_i || s_err_i || s_rty_i),
    .fire     (wd_fire)
  );

  // Read data is broadcast; only the granted master gets an ack to qualify it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Next-state: on contention the master that was not granted last wins.
  // A grant is only released by cyc falling or the watchdog firing.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (last_q) begin
            state_d = GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = GNT1;
            last_d  = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i || wd_fire) begin
          state_d = IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i || wd_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Zero-latency mux. Reset gates everything so the slave sees cyc drop in
  // the very cycle reset is raised, even mid-burst.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_bte_o  = '0;
    s_cti_o  = '0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    if (!wb_rst_i) begin
      case (state_q)
        GNT0: begin
          s_adr_o  = m0_adr_i;
          s_dat_o  = m0_dat_i;
          s_sel_o  = m0_sel_i;
          s_we_o   = m0_we_i;
          s_bte_o  = m0_bte_i;
          s_cti_o  = m0_cti_i;
          s_cyc_o  = m0_cyc_i && !wd_fire;
          s_stb_o  = m0_stb_i && !wd_fire;
          m0_ack_o = s_ack_i;
          m0_err_o = s_err_i || wd_fire;
          m0_rty_o = s_rty_i;
        end
        GNT1: begin
          s_adr_o  = m1_adr_i;
          s_dat_o  = m1_dat_i;
          s_sel_o  = m1_sel_i;
          s_we_o   = m1_we_i;
          s_bte_o  = m1_bte_i;
          s_cti_o  = m1_cti_i;
          s_cyc_o  = m1_cyc_i && !wd_fire;
          s_stb_o  = m1_stb_i && !wd_fire;
          m1_ack_o = s_ack_i;
          m1_err_o = s_err_i || wd_fire;
          m1_rty_o = s_rty_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arb2_b3.sv
// tb_wb_arb2_b3
// Directed testbench for wb_arb2_b3. One arbiter (timeout 4) sits in front of
// a small registered-ack RAM model; a second arbiter with the watchdog
// disabled shares the master inputs and faces a slave that never answers.

module tb_wb_arb2_b3;
  import wb_arb_pkg::*;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;

  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m1_we_i, m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i;
  logic [1:0]  m0_bte_i, m1_bte_i;
  logic [2:0]  m0_cti_i, m1_cti_i;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0]  s_bte_o;
  logic [2:0]  s_cti_o;

  logic [31:0] n_m0_dat_o, n_m1_dat_o, n_s_adr_o, n_s_dat_o;
  logic        n_m0_ack_o, n_m0_err_o, n_m0_rty_o, n_m1_ack_o, n_m1_err_o, n_m1_rty_o;
  logic [3:0]  n_s_sel_o;
  logic        n_s_we_o, n_s_cyc_o, n_s_stb_o;
  logic [1:0]  n_s_bte_o;
  logic [2:0]  n_s_cti_o;

  logic        stall = 1'b0;
  logic        ack_q;
  int          passed = 0;
  int          total  = 0;

  // Free-running clock, 10 time units per cycle
  always #5 wb_clk_i = ~wb_clk_i;

  wb_arb2_b3 #(.dw(32), .aw(32), .timeout_cycles(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_bte_i(m0_bte_i), .m0_cti_i(m0_cti_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_bte_i(m1_bte_i), .m1_cti_i(m1_cti_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_bte_o(s_bte_o), .s_cti_o(s_cti_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(1'b0), .s_rty_i(1'b0)
  );

  wb_arb2_b3 #(.dw(32), .aw(32), .timeout_cycles(0)) dut_nowd (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_bte_i(m0_bte_i), .m0_cti_i(m0_cti_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_dat_o(n_m0_dat_o), .m0_ack_o(n_m0_ack_o), .m0_err_o(n_m0_err_o), .m0_rty_o(n_m0_rty_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_bte_i(m1_bte_i), .m1_cti_i(m1_cti_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_dat_o(n_m1_dat_o), .m1_ack_o(n_m1_ack_o), .m1_err_o(n_m1_err_o), .m1_rty_o(n_m1_rty_o),
    .s_adr_o(n_s_adr_o), .s_dat_o(n_s_dat_o), .s_sel_o(n_s_sel_o), .s_we_o(n_s_we_o),
    .s_bte_o(n_s_bte_o), .s_cti_o(n_s_cti_o), .s_cyc_o(n_s_cyc_o), .s_stb_o(n_s_stb_o),
    .s_dat_i(32'h0), .s_ack_i(1'b0), .s_err_i(1'b0), .s_rty_i(1'b0)
  );

  // RAM contents: one known word at 0x10, everything else tagged by address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {16'hA5A5, a[15:0]};
  endfunction

  assign s_dat_i = mem_word(s_adr_o);
  assign s_ack_i = ack_q;

  // RAM-style slave: registered ack, toggling for classic/EOB beats and held
  // high for burst beats; stall suppresses every response
  always @(posedge wb_clk_i) begin
    if (wb_rst_i) ack_q <= 1'b0;
    else if (s_cyc_o && s_stb_o && !stall)
      ack_q <= (s_cti_o == CLASSIC || s_cti_o == EOB) ? !ack_q : 1'b1;
    else ack_q <= 1'b0;
  end

  // Inputs change just after the rising edge; outputs are sampled at the falling edge
  task automatic next_cycle();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge wb_clk_i);
  endtask

  // Both masters drop every request line
  task automatic clear_masters();
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = 4'hF; m0_we_i = 1'b0;
    m0_bte_i = LINEAR; m0_cti_i = CLASSIC; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = 4'hF; m1_we_i = 1'b0;
    m1_bte_i = LINEAR; m1_cti_i = CLASSIC; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      clear_masters();
    end
  endtask

  // One reset cycle followed by one quiet cycle
  task automatic do_reset();
    next_cycle();
    clear_masters();
    wb_rst_i = 1'b1;
    next_cycle();
    wb_rst_i = 1'b0;
  endtask

  // Reset gating with both masters requesting, then quiet IDLE state
  task automatic test_reset();
    next_cycle();
    clear_masters();
    wb_rst_i = 1'b1;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    sample();
    total++; if (s_cyc_o !== 1'b0) $display("[TB] FAIL reset_cyc: s_cyc_o=%b expected 0", s_cyc_o); else passed++;
    total++; if (s_stb_o !== 1'b0) $display("[TB] FAIL reset_stb: s_stb_o=%b expected 0", s_stb_o); else passed++;
    next_cycle();
    next_cycle();
    wb_rst_i = 1'b0;
    clear_masters();
    sample();
    total++; if (s_cyc_o !== 1'b0) $display("[TB] FAIL reset_idle: s_cyc_o=%b expected 0", s_cyc_o); else passed++;
    total++; if (n_s_cyc_o !== 1'b0) $display("[TB] FAIL reset_idle_nowd: s_cyc_o=%b expected 0", n_s_cyc_o); else passed++;
  endtask

  // Simultaneous request right after reset, handover, then round-robin repeat
  task automatic test_contention();
    do_reset();
    next_cycle();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h20;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h30;
    sample();
    total++; if (s_cyc_o !== 1'b0) $display("[TB] FAIL cont_latency: s_cyc_o=%b expected 0", s_cyc_o); else passed++;
    next_cycle();
    sample();
    total++; if (s_adr_o !== 32'h20) $display("[TB] FAIL cont_first_m0: s_adr_o=%h expected 00000020", s_adr_o); else passed++;
    next_cycle();
    sample();
    total++; if (m0_ack_o !== 1'b1) $display("[TB] FAIL cont_m0_ack: m0_ack_o=%b expected 1", m0_ack_o); else passed++;
    total++; if (m1_ack_o !== 1'b0) $display("[TB] FAIL cont_m1_blocked: m1_ack_o=%b expected 0", m1_ack_o); else passed++;
    next_cycle();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    next_cycle();
    sample();
    total++; if (s_cyc_o !== 1'b0) $display("[TB] FAIL cont_gap_idle: s_cyc_o=%b expected 0", s_cyc_o); else passed++;
    next_cycle();
    sample();
    total++; if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h30)
      $display("[TB] FAIL cont_m1_grant: s_cyc_o=%b s_adr_o=%h expected 1/00000030", s_cyc_o, s_adr_o); else passed++;
    next_cycle();
    sample();
    total++; if (m1_ack_o !== 1'b1) $display("[TB] FAIL cont_m1_ack: m1_ack_o=%b expected 1", m1_ack_o); else passed++;
    total++; if (m1_dat_o !== 32'hA5A50030) $display("[TB] FAIL cont_m1_data: m1_dat_o=%h expected a5a50030", m1_dat_o); else passed++;
    total++; if (m0_ack_o !== 1'b0) $display("[TB] FAIL cont_m0_blocked: m0_ack_o=%b expected 0", m0_ack_o); else passed++;
    next_cycle();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    next_cycle();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    next_cycle();
    sample();
    total++; if (s_adr_o !== 32'h20) $display("[TB] FAIL cont_rr_m0_again: s_adr_o=%h expected 00000020", s_adr_o); else passed++;
    idle_cycles(3);
  endtask

  // m0 classic read of 0x10 while m1 stays idle
  task automatic test_single();
    logic m1_ack_seen;
    m1_ack_seen = 1'b0;
    next_cycle();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h10; m0_cti_i = CLASSIC;
    sample();
    m1_ack_seen |= m1_ack_o;
    total++; if (s_cyc_o !== 1'b0) $display("[TB] FAIL single_latency: s_cyc_o=%b expected 0", s_cyc_o); else passed++;
    next_cycle();
    sample();
    m1_ack_seen |= m1_ack_o;
    total++; if (s_cyc_o !== 1'b1) $display("[TB] FAIL single_grant: s_cyc_o=%b expected 1", s_cyc_o); else passed++;
    next_cycle();
    sample();
    m1_ack_seen |= m1_ack_o;
    total++; if (m0_ack_o !== 1'b1) $display("[TB] FAIL single_ack: m0_ack_o=%b expected 1", m0_ack_o); else passed++;
    total++; if (m0_dat_o !== 32'hDEADBEEF) $display("[TB] FAIL single_data: m0_dat_o=%h expected deadbeef", m0_dat_o); else passed++;
    next_cycle();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    sample();
    m1_ack_seen |= m1_ack_o;
    total++; if (m1_ack_seen !== 1'b0) $display("[TB] FAIL single_m1_quiet: m1_ack seen=%b expected 0", m1_ack_seen); else passed++;
    idle_cycles(3);
  endtask

  // m1 WRAP4 burst from 0x08 with m0 requesting mid-burst
  task automatic test_burst_hold();
    logic [31:0] addrs [4];
    int          ack_count;
    addrs[0] = 32'h08; addrs[1] = 32'h0C; addrs[2] = 32'h00; addrs[3] = 32'h04;
    ack_count = 0;
    next_cycle();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = addrs[0]; m1_cti_i = INCR; m1_bte_i = WRAP4;
    next_cycle();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h40; m0_cti_i = CLASSIC;
    sample();
    total++; if (s_adr_o !== 32'h08 || m1_ack_o !== 1'b0)
      $display("[TB] FAIL burst_first_wait: s_adr_o=%h ack=%b expected 00000008/0", s_adr_o, m1_ack_o); else passed++;
    for (int b = 0; b < 4; b++) begin
      next_cycle();
      m1_adr_i = addrs[b];
      m1_cti_i = (b == 3) ? EOB : INCR;
      sample();
      if (m1_ack_o === 1'b1 && m1_dat_o === {16'hA5A5, addrs[b][15:0]} && m0_ack_o === 1'b0)
        ack_count++;
      else
        $display("[TB] beat %0d: ack=%b dat=%h m0_ack=%b", b, m1_ack_o, m1_dat_o, m0_ack_o);
    end
    total++; if (s_cti_o !== EOB) $display("[TB] FAIL burst_eob: s_cti_o=%b expected 111", s_cti_o); else passed++;
    total++; if (ack_count !== 4) $display("[TB] FAIL burst_beats: good acked beats=%0d expected 4", ack_count); else passed++;
    next_cycle();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_cti_i = CLASSIC; m1_bte_i = LINEAR;
    sample();
    total++; if (m0_ack_o !== 1'b0) $display("[TB] FAIL burst_m0_waits: m0_ack_o=%b expected 0", m0_ack_o); else passed++;
    next_cycle();
    sample();
    total++; if (s_cyc_o !== 1'b0) $display("[TB] FAIL burst_gap: s_cyc_o=%b expected 0", s_cyc_o); else passed++;
    next_cycle();
    sample();
    total++; if (s_adr_o !== 32'h40 || s_cyc_o !== 1'b1)
      $display("[TB] FAIL burst_m0_grant: s_adr_o=%h cyc=%b expected 00000040/1", s_adr_o, s_cyc_o); else passed++;
    idle_cycles(3);
  endtask

  // Timeout of 4 against a stalled slave
  task automatic test_watchdog();
    logic early_err;
    early_err = 1'b0;
    stall = 1'b1;
    next_cycle();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h50;
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      sample();
      early_err |= m0_err_o;
    end
    total++; if (early_err !== 1'b0) $display("[TB] FAIL wd_early: err seen=%b expected 0", early_err); else passed++;
    next_cycle();
    sample();
    total++; if (m0_err_o !== 1'b1) $display("[TB] FAIL wd_fire: m0_err_o=%b expected 1", m0_err_o); else passed++;
    total++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0)
      $display("[TB] FAIL wd_mask: s_cyc_o=%b s_stb_o=%b expected 0/0", s_cyc_o, s_stb_o); else passed++;
    total++; if (m1_err_o !== 1'b0) $display("[TB] FAIL wd_other: m1_err_o=%b expected 0", m1_err_o); else passed++;
    next_cycle();
    sample();
    total++; if (s_cyc_o !== 1'b0 || m0_err_o !== 1'b0)
      $display("[TB] FAIL wd_idle: s_cyc_o=%b err=%b expected 0/0", s_cyc_o, m0_err_o); else passed++;
    stall = 1'b0;
    idle_cycles(3);
  endtask

  // Reset raised during an m0 write burst, then a fresh contention
  task automatic test_reset_mid();
    next_cycle();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 32'h60;
    m0_dat_i = 32'h12345678; m0_cti_i = INCR;
    next_cycle();
    sample();
    total++; if (s_we_o !== 1'b1) $display("[TB] FAIL rst_mid_setup: s_we_o=%b expected 1", s_we_o); else passed++;
    next_cycle();
    wb_rst_i = 1'b1;
    sample();
    total++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_we_o !== 1'b0)
      $display("[TB] FAIL rst_mid_gate: cyc=%b stb=%b we=%b expected 0/0/0", s_cyc_o, s_stb_o, s_we_o); else passed++;
    next_cycle();
    wb_rst_i = 1'b0;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h70;
    sample();
    total++; if (s_cyc_o !== 1'b0) $display("[TB] FAIL rst_mid_idle: s_cyc_o=%b expected 0", s_cyc_o); else passed++;
    next_cycle();
    sample();
    total++; if (s_adr_o !== 32'h60 || s_cyc_o !== 1'b1)
      $display("[TB] FAIL rst_mid_m0_wins: s_adr_o=%h cyc=%b expected 00000060/1", s_adr_o, s_cyc_o); else passed++;
    idle_cycles(3);
  endtask

  // Disabled watchdog holds the grant against a dead slave for 1000 cycles
  task automatic test_no_watchdog();
    logic err_seen, grant_lost;
    err_seen = 1'b0;
    grant_lost = 1'b0;
    do_reset();
    next_cycle();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h80;
    for (int k = 0; k < 1000; k++) begin
      next_cycle();
      sample();
      err_seen   |= n_m0_err_o | n_m1_err_o;
      grant_lost |= (n_s_cyc_o !== 1'b1);
    end
    total++; if (err_seen !== 1'b0) $display("[TB] FAIL nowd_err: err seen=%b expected 0", err_seen); else passed++;
    total++; if (grant_lost !== 1'b0) $display("[TB] FAIL nowd_hold: grant lost=%b expected 0", grant_lost); else passed++;
    idle_cycles(2);
  endtask

  // Scenario sequence and summary
  initial begin
    clear_masters();
    test_reset();
    test_contention();
    test_single();
    test_burst_hold();
    test_watchdog();
    test_reset_mid();
    test_no_watchdog();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
